puerto_entrada: RTL and testbench

PUERTO_ENTRADA -- requirements
Module: puerto_entrada

---
 rtl/puerto_pkg.sv | 27 ++
 rtl/mem_fifo.sv | 42 ++++
 rtl/puerto_entrada.sv | 175 +++++++++++++++++
 tb/tb_puerto_entrada.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puerto_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puerto_pkg
//  Description : Shared defaults and helper function for the puerto_entrada
//                input port: default data width, default FIFO depth and the
//                pointer-width constant function.
//  Revision    : 1.0 - initial release
// ============================================================================
package puerto_pkg;

  // Default datapath width in bits.
  localparam int unsigned PUERTO_WIDTH_DEF = 8;

  // Default number of FIFO entries (power of two, 2..16).
  localparam int unsigned PUERTO_DEPTH_DEF = 4;

  // Bits needed to address 'depth' entries. Clamped to 1 so a degenerate
  // depth still yields a legal vector width.
  function automatic int unsigned ptr_width(input int unsigned depth);
    if (depth > 1) begin
      return $clog2(depth);
    end
    return 1;
  endfunction

endpackage : puerto_pkg
`default_nettype wire

// File: rtl/mem_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_fifo
//  Description : Storage array for the input-port FIFO. One synchronous
//                write port and one asynchronous (combinational) read port.
//                Contents are deliberately not reset.
//
//  Ports
//    clk      in   clock, write happens on rising edge
//    i_we     in   write enable
//    i_waddr  in   write address
//    i_wdata  in   write data
//    i_raddr  in   read address
//    o_rdata  out  data stored at i_raddr (combinational)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : mem_fifo
`default_nettype wire

// File: rtl/puerto_entrada.sv
`default_nettype none
// ============================================================================
//  Module      : puerto_entrada
//  Description : Input port between an external valid/ready producer and a
//                CPU that pops words with a read strobe. Data is buffered in
//                a DEPTH-entry FIFO (mem_fifo); pointer and occupancy control
//                live here. A sticky error flag records reads while empty.
//
//  Configuration macro
//    PUERTO_ENTRADA_IRQ_EN  when defined, adds registered output 'irq'
//                           equal to !empty delayed by one cycle.
//
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   synchronous active-high reset
//    ext_data   in   producer data
//    ext_valid  in   producer offers ext_data
//    ext_ready  out  block accepts data this cycle (= !full)
//    rd         in   CPU pop strobe
//    dout       out  head-of-FIFO word, zero while empty
//    empty      out  FIFO holds no words
//    full       out  FIFO holds DEPTH words
//    count      out  number of stored words
//    clr_err    in   clears err (a same-edge underflow wins)
//    err        out  sticky underflow flag
//    irq        out  (optional) registered !empty, one cycle late
//
//  DEPTH must be a power of two in 2..16 so pointers wrap naturally.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module puerto_entrada
  import puerto_pkg::*;
#(
  parameter int unsigned WIDTH = PUERTO_WIDTH_DEF,
  parameter int unsigned DEPTH = PUERTO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       ext_data,
  input  logic                   ext_valid,
  output logic                   ext_ready,
  input  logic                   rd,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   clr_err,
  output logic                   err
`ifdef PUERTO_ENTRADA_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] C_PTR_ONE    = PW'(1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_err;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_rdata;

  // Status depends only on the registered count, so ext_ready has no
  // combinational path from ext_valid or rd.
  assign w_full  = (r_count == C_FULL_COUNT);
  assign w_empty = (r_count == '0);

  assign w_push      = ext_valid && !w_full;
  assign w_pop       = rd && !w_empty;
  assign w_underflow = rd && w_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      r_count <= w_count_nxt;
    end
  end

  // Sticky underflow flag: a new underflow beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_underflow) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  // Write is gated by !reset so a word offered during reset is dropped
  // rather than silently landing in the array.
  mem_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem_fifo (
    .clk     (clk),
    .i_we    (w_push && !reset),
    .i_waddr (r_wptr),
    .i_wdata (ext_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Array contents are never reset, so mask them while the FIFO is empty.
  assign dout      = w_empty ? '0 : w_rdata;
  assign ext_ready = !w_full;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign err       = r_err;

`ifdef PUERTO_ENTRADA_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= !w_empty;
    end
  end

  assign irq = r_irq;
`endif

endmodule : puerto_entrada
`default_nettype wire

// File: tb/tb_puerto_entrada.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puerto_entrada
//  Description : Self-checking bench for puerto_entrada (WIDTH=8, DEPTH=4).
//                A queue-based model tracks contents, err and irq; every
//                cycle the DUT outputs are compared to it. Directed sequences
//                add literal expectations, then a randomized phase follows.
//                Honors PUERTO_ENTRADA_IRQ_EN to exercise the irq output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puerto_entrada;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] ext_data;
  logic             ext_valid;
  logic             ext_ready;
  logic             rd;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             clr_err;
  logic             err;
`ifdef PUERTO_ENTRADA_IRQ_EN
  logic             irq;
`endif

  puerto_entrada #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .rd        (rd),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .clr_err   (clr_err),
    .err       (err)
`ifdef PUERTO_ENTRADA_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  logic [WIDTH-1:0] m_q[$];
  logic             m_err = 1'b0;
  logic             m_irq = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
    ext_valid = v;
    ext_data  = d;
    rd        = r;
    clr_err   = c;
  endtask

  // Advance one clock: update the model from the inputs the DUT sampled at
  // this edge, then compare every output shortly after the edge.
  task automatic cycle();
    int  sz;
    bit  do_push;
    bit  do_pop;
    @(posedge clk);
    sz = m_q.size();
    if (reset) begin
      m_q.delete();
      m_err = 1'b0;
      m_irq = 1'b0;
    end else begin
      m_irq   = (sz != 0);
      do_push = ext_valid && (sz < DEPTH);
      do_pop  = rd && (sz > 0);
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(ext_data);
      if (rd && sz == 0) m_err = 1'b1;
      else if (clr_err)  m_err = 1'b0;
    end
    #1;
    sz = m_q.size();
    check("count",     32'(count),     32'(sz));
    check("empty",     32'(empty),     32'(sz == 0));
    check("full",      32'(full),      32'(sz == DEPTH));
    check("ext_ready", 32'(ext_ready), 32'(sz != DEPTH));
    check("dout",      32'(dout),      (sz != 0) ? 32'(m_q[0]) : 32'h0);
    check("err",       32'(err),       32'(m_err));
`ifdef PUERTO_ENTRADA_IRQ_EN
    check("irq",       32'(irq),       32'(m_irq));
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] fill  [4];
    logic [WIDTH-1:0] order [4];
    logic [WIDTH-1:0] v;
    int               ph;

    fill  = '{8'h11, 8'h22, 8'h33, 8'h44};
    order = '{8'h22, 8'h33, 8'h44, 8'h55};

    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset then idle
    check("rst_empty", 32'(empty),     32'd1);
    check("rst_count", 32'(count),     32'd0);
    check("rst_dout",  32'(dout),      32'h00);
    check("rst_ready", 32'(ext_ready), 32'd1);
    check("rst_err",   32'(err),       32'd0);

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill[i], 1'b0, 1'b0);
      cycle();
    end
    check("fill_full",  32'(full),      32'd1);
    check("fill_ready", 32'(ext_ready), 32'd0);
    check("fill_dout",  32'(dout),      32'h11);

    // Fifth word held off
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    cycle();
    check("hold_count", 32'(count), 32'd4);
    check("hold_dout",  32'(dout),  32'h11);

    // Pop while full with valid 0x55: pop only, push next cycle
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    cycle();
    check("popfull_count", 32'(count),     32'd3);
    check("popfull_ready", 32'(ext_ready), 32'd1);
    check("popfull_dout",  32'(dout),      32'h22);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    cycle();
    check("late_push_count", 32'(count), 32'd4);

    for (int i = 0; i < 4; i++) begin
      check("read_order", 32'(dout), 32'(order[i]));
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
    end
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_err",   32'(err),   32'd0);

    // Simultaneous push/pop at count=1
    drive(1'b1, 8'h7A, 1'b0, 1'b0);
    cycle();
    check("one_dout", 32'(dout), 32'h7A);
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle();
    check("pp_count", 32'(count), 32'd1);
    check("pp_dout",  32'(dout),  32'h3C);
    for (int i = 0; i < 10; i++) begin
      v = 8'(8'h80 + i);
      drive(1'b1, v, 1'b1, 1'b0);
      cycle();
      check("wrap_dout",  32'(dout),  32'(v));
      check("wrap_count", 32'(count), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();

    // Underflow and sticky err
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    check("uf_err",   32'(err),   32'd1);
    check("uf_count", 32'(count), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b1);
    cycle();
    check("uf_clr_same", 32'(err), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle();
    check("clr_alone", 32'(err), 32'd0);

    // Underflow with a concurrent push still pushes
    drive(1'b1, 8'hE5, 1'b1, 1'b0);
    cycle();
    check("uf_push_count", 32'(count), 32'd1);
    check("uf_push_dout",  32'(dout),  32'hE5);
    check("uf_push_err",   32'(err),   32'd1);
    drive(1'b0, '0, 1'b1, 1'b1);
    cycle();

`ifdef PUERTO_ENTRADA_IRQ_EN
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle();
    check("irq_idle", 32'(irq), 32'd0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle();
    check("irq_lag_empty", 32'(empty), 32'd0);
    check("irq_lag",       32'(irq),   32'd0);
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    cycle();
    check("irq_rise", 32'(irq), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("irq_rst",       32'(irq),   32'd0);
    check("irq_rst_count", 32'(count), 32'd0);
`endif

    // Randomized phases alternate between fill-heavy and drain-heavy traffic
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 100) % 3;
      reset = ($urandom_range(0, 127) == 0);
      drive(
        (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1),
        8'($urandom),
        (ph == 0) ? ($urandom_range(0, 9) < 2) : (ph == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1),
        ($urandom_range(0, 7) == 0)
      );
      cycle();
    end
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_puerto_entrada
`default_nettype wire
